uart_rx_mmio: RTL

UART_RX_MMIO -- requirements
Module: uart_rx_mmio

---
 rtl/uart_rx_mmio.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_mmio.sv
`timescale 1ns/1ps
// 8N1 UART receiver feeding an RX FIFO, exposed through a 16-byte MMIO window (RXDATA/STATUS/CTRL).
// Loads are combinational and complete in one cycle; a byte arriving at a full FIFO is dropped and flags overrun.
module uart_rx_mmio #(
   parameter int          CLK_FREQ   = 50000000,
   parameter int          BAUD_RATE  = 115200,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0010
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_pin,
   input  logic        bus_valid,
   input  logic        bus_write,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] mmio_rdata,
   output logic        uart_ready,
   output logic        rx_irq
);
   localparam int DIV = CLK_FREQ / BAUD_RATE;
   localparam int CW  = $clog2(DIV);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]    sync;
   logic          rx_sync;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          stop_wait;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          overrun, frame_err;
   logic          sel, nonempty, full, busy, pop, stop_smp, push_req, push_do, frm_set, ctrl_wr;
   logic [1:0]    off;
   logic [7:0]    head_byte;
   logic          unused;

   assign unused     = ^{bus_addr[1:0], bus_wdata[31:2]};
   assign uart_ready = 1'b1;

   assign sel       = bus_valid && (bus_addr[31:4] == BASE_ADDR[31:4]);
   assign off       = bus_addr[3:2];
   assign nonempty  = (count != '0);
   assign full      = (count == FULL_CNT);
   assign busy      = (state != S_IDLE);
   assign pop       = sel && !bus_write && (off == 2'd0) && nonempty;
   assign ctrl_wr   = sel && bus_write && (off == 2'd2);
   assign head_byte = nonempty ? mem[rd_ptr] : 8'h00;

   // Stop-bit sample point; a low stop bit parks the FSM in STOP until the line idles again.
   assign stop_smp = (state == S_STOP) && !stop_wait && (cnt == BIT_END);
   assign push_req = stop_smp && rx_sync;
   assign frm_set  = stop_smp && !rx_sync;
   assign push_do  = push_req && (!full || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], rx_pin};
   end
   assign rx_sync = sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         stop_wait <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (!rx_sync) state <= S_START;
            end
            S_START: begin
               if (cnt == HALF_END) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_sync ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt == BIT_END) begin
                  cnt     <= '0;
                  shreg   <= {rx_sync, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               if (stop_wait) begin
                  if (rx_sync) begin
                     stop_wait <= 1'b0;
                     state     <= S_IDLE;
                  end
               end else if (cnt == BIT_END) begin
                  cnt       <= '0;
                  stop_wait <= !rx_sync;
                  if (rx_sync) state <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_do) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rx_irq <= 1'b0;
      end else begin
         if (push_do) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_do && !pop)      count <= count + 1'b1;
         else if (pop && !push_do) count <= count - 1'b1;
         rx_irq <= nonempty;
      end
   end

   // Setting an error flag takes priority over a same-cycle CTRL clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (push_req && full && !pop)      overrun <= 1'b1;
         else if (ctrl_wr && bus_wdata[1])  overrun <= 1'b0;
         if (frm_set)                       frame_err <= 1'b1;
         else if (ctrl_wr && bus_wdata[0])  frame_err <= 1'b0;
      end
   end

   always_comb begin
      mmio_rdata = '0;
      if (sel) begin
         case (off)
            2'd0:    mmio_rdata = {nonempty, 23'b0, head_byte};
            2'd1:    mmio_rdata = {27'b0, busy, overrun, frame_err, full, nonempty};
            default: mmio_rdata = '0;
         endcase
      end
   end
endmodule
